// File: rtl/uart_cfg_rx_if.sv
// Serial input and committed-parameter outputs of the UART configuration receiver.
// The slave modport is the receiver; the master modport is the host side that drives the line.
interface uart_cfg_rx_if #(
    parameter int unsigned PAR_NUM = 5,
    parameter int unsigned PAR_W   = 8
);
    logic                     uart_data;
    logic [PAR_NUM*PAR_W-1:0] par_out;
    logic                     upd_stb;
    logic                     busy;
    logic                     frame_err;
    logic                     chk_err;

    modport master (
        output uart_data,
        input  par_out,
        input  upd_stb,
        input  busy,
        input  frame_err,
        input  chk_err
    );

    modport slave (
        input  uart_data,
        output par_out,
        output upd_stb,
        output busy,
        output frame_err,
        output chk_err
    );
endinterface

// File: rtl/uart_cfg_rx.sv
// UART configuration receiver: deserialises a packet of PAR_NUM parameters (MSB byte first),
// optionally checks a trailing XOR checksum and commits all parameters at once.
module uart_cfg_rx #(
    parameter int unsigned CLK_DIV      = 16,
    parameter int unsigned PAR_NUM      = 5,
    parameter int unsigned PAR_W        = 8,
    parameter int unsigned CHECKSUM_EN  = 1,
    parameter int unsigned TIMEOUT_BITS = 24
) (
    input logic          clk,
    input logic          rst,
    uart_cfg_rx_if.slave bus
);
    localparam int unsigned HALF   = CLK_DIV / 2;
    localparam int unsigned CW     = $clog2(CLK_DIV);
    localparam int unsigned PW     = PAR_NUM * PAR_W;
    localparam int unsigned NBYTES = PW / 8;
    localparam int unsigned TOTAL  = NBYTES + ((CHECKSUM_EN != 0) ? 1 : 0);
    localparam int unsigned BCW    = $clog2(TOTAL + 1);
    localparam int unsigned TO_CYC = TIMEOUT_BITS * CLK_DIV;
    localparam int unsigned TOW    = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StRecover} bit_st_e;

    // Bit-level state
    logic [1:0]    sync_q;
    logic          rx_prev_q;
    bit_st_e       st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx, fall;
    logic          start_ok, byte_ok, stop_bad;

    // Packet-level state
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [PW-1:0]  shadow_q, shadow_d;
    logic [PW-1:0]  par_q, par_d;
    logic [7:0]     chk_q, chk_d;
    logic [TOW-1:0] to_q, to_d;
    logic           busy_q, busy_d;
    logic           upd_q, upd_d;
    logic           ferr_q, ferr_d;
    logic           cerr_q, cerr_d;
    logic           last_byte;

    assign rx        = sync_q[1];
    assign fall      = rx_prev_q & ~rx;
    assign last_byte = (byte_cnt_q == BCW'(TOTAL - 1));

    // Synchroniser, edge history and bit FSM registers; line resets to idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            st_q      <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            sync_q    <= {sync_q[0], bus.uart_data};
            rx_prev_q <= rx;
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    // Bit FSM: mid-bit sampling of start, 8 data bits (MSB first) and stop
    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        start_ok = 1'b0;
        byte_ok  = 1'b0;
        stop_bad = 1'b0;
        unique case (st_q)
            StIdle: begin
                cnt_d = '0;
                if (fall) st_d = StStart;
            end
            StStart: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d = '0;
                    if (rx) begin
                        st_d = StIdle;  // glitch
                    end else begin
                        st_d     = StData;
                        bit_d    = '0;
                        start_ok = 1'b1;
                    end
                end
            end
            StData: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[6:0], rx};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) st_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (rx) begin
                        byte_ok = 1'b1;
                        st_d    = StIdle;
                    end else begin
                        stop_bad = 1'b1;
                        st_d     = StRecover;
                    end
                end
            end
            StRecover: begin
                // Wait for one full bit time of continuous high before hunting again
                if (!rx) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    st_d  = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    // Packet registers
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q <= '0;
            shadow_q   <= '0;
            par_q      <= '0;
            chk_q      <= '0;
            to_q       <= '0;
            busy_q     <= 1'b0;
            upd_q      <= 1'b0;
            ferr_q     <= 1'b0;
            cerr_q     <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shadow_q   <= shadow_d;
            par_q      <= par_d;
            chk_q      <= chk_d;
            to_q       <= to_d;
            busy_q     <= busy_d;
            upd_q      <= upd_d;
            ferr_q     <= ferr_d;
            cerr_q     <= cerr_d;
        end
    end

    // Packet assembly, checksum, timeout and atomic commit
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shadow_d   = shadow_q;
        par_d      = par_q;
        chk_d      = chk_q;
        to_d       = busy_q ? to_q + 1'b1 : '0;
        busy_d     = busy_q;
        upd_d      = 1'b0;
        ferr_d     = ferr_q;
        cerr_d     = cerr_q;

        if (start_ok) begin
            busy_d = 1'b1;
            to_d   = '0;
        end else if (busy_q && to_q == TOW'(TO_CYC - 1)) begin
            // Silent abort of a stalled packet
            busy_d     = 1'b0;
            byte_cnt_d = '0;
            chk_d      = '0;
            to_d       = '0;
        end

        if (stop_bad) begin
            ferr_d     = 1'b1;
            busy_d     = 1'b0;
            byte_cnt_d = '0;
            chk_d      = '0;
            to_d       = '0;
        end else if (byte_ok) begin
            to_d = '0;
            if (byte_cnt_q < BCW'(NBYTES)) begin
                shadow_d = (shadow_q << 8) | PW'(shift_q);
                chk_d    = chk_q ^ shift_q;
            end
            if (last_byte) begin
                byte_cnt_d = '0;
                busy_d     = 1'b0;
                chk_d      = '0;
                if (CHECKSUM_EN == 0 || shift_q == chk_q) begin
                    // Without a checksum byte the final payload byte is still in flight
                    par_d  = (CHECKSUM_EN != 0) ? shadow_q : shadow_d;
                    upd_d  = 1'b1;
                    ferr_d = 1'b0;
                    cerr_d = 1'b0;
                end else begin
                    cerr_d = 1'b1;
                end
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end
    end

    assign bus.par_out   = par_q;
    assign bus.upd_stb   = upd_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = ferr_q;
    assign bus.chk_err   = cerr_q;
endmodule
